// File: rtl/adc_idelay_train.sv
// ----------------------------------------------------------------------------
// adc_idelay_train : sweeps a shared IDELAY and parks it mid longest pass window
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adc_idelay_train #(
  parameter int ADC_DATA_WIDTH    = 8,
  parameter int PARALLEL_PATH_NUM = 2,
  parameter int TAP_NUM           = 32,
  parameter int TAP_W             = 5,
  parameter logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] TRAIN_PATTERN = 16'hA55A,
  parameter int SETTLE_CYCLES     = 16,
  parameter int CHECK_CYCLES      = 64
) (
  input  logic                                        adc_clk_bufr,
  input  logic                                        rst_train_sync,
  input  logic                                        train_start,
  input  logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] adc_parrel_i,
  output logic                                        rst_iserdes_sync,
  output logic                                        idelay_rst,
  output logic                                        idelay_ce,
  output logic                                        idelay_inc,
  output logic [TAP_W-1:0]                            tap_cur,
  output logic [TAP_W-1:0]                            tap_sel,
  output logic [TAP_W:0]                              win_len,
  output logic                                        train_done,
  output logic                                        train_fail
);

  localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ?
                           ((SETTLE_CYCLES > 8) ? SETTLE_CYCLES : 8) :
                           ((CHECK_CYCLES  > 8) ? CHECK_CYCLES  : 8);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(7);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_NUM - 1);
  localparam logic [TAP_W:0]   LEN_ONE     = (TAP_W+1)'(1);

  typedef enum logic [3:0] {
    S_RST, S_SETTLE, S_CHECK, S_EVAL, S_INC, S_CALC,
    S_REWIND, S_MOVE, S_FINAL, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAP_W-1:0]   tap_cur_q, tap_cur_d;
  logic [TAP_W-1:0]   tap_sel_q, tap_sel_d;
  logic [TAP_W:0]     win_len_q, win_len_d;
  logic               pass_q, pass_d;
  logic               run_open_q, run_open_d;
  logic [TAP_W-1:0]   run_start_q, run_start_d;
  logic [TAP_W:0]     run_len_q, run_len_d;
  logic [TAP_W-1:0]   best_start_q, best_start_d;
  logic [TAP_W:0]     best_len_q, best_len_d;
  logic               move_idle_q, move_idle_d;
  logic               rst_iserdes_q, rst_iserdes_d;
  logic               idelay_rst_q, idelay_rst_d;
  logic               idelay_ce_q, idelay_ce_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;

  logic [TAP_W:0]     cand_len;
  logic [TAP_W-1:0]   cand_start;
  logic [TAP_W:0]     centre;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tap_cur_d     = tap_cur_q;
    tap_sel_d     = tap_sel_q;
    win_len_d     = win_len_q;
    pass_d        = pass_q;
    run_open_d    = run_open_q;
    run_start_d   = run_start_q;
    run_len_d     = run_len_q;
    best_start_d  = best_start_q;
    best_len_d    = best_len_q;
    move_idle_d   = move_idle_q;
    rst_iserdes_d = rst_iserdes_q;
    idelay_rst_d  = 1'b0;
    idelay_ce_d   = 1'b0;
    done_d        = done_q;
    fail_d        = fail_q;
    cand_len      = run_open_q ? run_len_q + LEN_ONE : LEN_ONE;
    cand_start    = run_open_q ? run_start_q : tap_cur_q;
    centre        = {1'b0, best_start_q} + ((best_len_q - LEN_ONE) >> 1);

    // Outputs are registered, so each branch sets what the next state drives.
    case (state_q)
      S_RST: begin
        tap_cur_d     = '0;
        rst_iserdes_d = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d       = S_SETTLE;
          cnt_d         = '0;
          rst_iserdes_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CHECK: begin
        pass_d = ((cnt_q == '0) ? 1'b1 : pass_q) & (adc_parrel_i == TRAIN_PATTERN);
        if (cnt_q == CHECK_LAST) begin
          state_d = S_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_EVAL: begin
        if (pass_q) begin
          run_open_d  = 1'b1;
          run_len_d   = cand_len;
          run_start_d = cand_start;
          if (tap_cur_q == TAP_LAST && cand_len > best_len_q) begin
            best_len_d   = cand_len;
            best_start_d = cand_start;
          end
        end else begin
          run_open_d = 1'b0;
          run_len_d  = '0;
          if (run_open_q && run_len_q > best_len_q) begin
            best_len_d   = run_len_q;
            best_start_d = run_start_q;
          end
        end
        if (tap_cur_q < TAP_LAST) begin
          state_d     = S_INC;
          idelay_ce_d = 1'b1;
        end else begin
          state_d = S_CALC;
        end
      end
      S_INC: begin
        tap_cur_d = tap_cur_q + TAP_ONE;
        state_d   = S_SETTLE;
        cnt_d     = '0;
      end
      S_CALC: begin
        tap_cur_d = '0;
        if (best_len_q == '0) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          tap_sel_d    = centre[TAP_W-1:0];
          win_len_d    = best_len_q;
          state_d      = S_REWIND;
          idelay_rst_d = 1'b1;
        end
      end
      S_REWIND: begin
        cnt_d = '0;
        if (tap_sel_q == '0) begin
          state_d = S_FINAL;
        end else begin
          state_d     = S_MOVE;
          move_idle_d = 1'b0;
          idelay_ce_d = 1'b1;
        end
      end
      S_MOVE: begin
        if (!move_idle_q) begin
          tap_cur_d   = tap_cur_q + TAP_ONE;
          move_idle_d = 1'b1;
        end else if (tap_cur_q == tap_sel_q) begin
          state_d = S_FINAL;
          cnt_d   = '0;
        end else begin
          move_idle_d = 1'b0;
          idelay_ce_d = 1'b1;
        end
      end
      S_FINAL: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE, S_FAIL: begin
        if (train_start) begin
          state_d       = S_RST;
          cnt_d         = '0;
          tap_cur_d     = '0;
          win_len_d     = '0;
          run_open_d    = 1'b0;
          run_start_d   = '0;
          run_len_d     = '0;
          best_start_d  = '0;
          best_len_d    = '0;
          done_d        = 1'b0;
          fail_d        = 1'b0;
          rst_iserdes_d = 1'b1;
          idelay_rst_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge adc_clk_bufr) begin
    if (rst_train_sync) begin
      state_q       <= S_RST;
      cnt_q         <= '0;
      tap_cur_q     <= '0;
      tap_sel_q     <= '0;
      win_len_q     <= '0;
      pass_q        <= 1'b0;
      run_open_q    <= 1'b0;
      run_start_q   <= '0;
      run_len_q     <= '0;
      best_start_q  <= '0;
      best_len_q    <= '0;
      move_idle_q   <= 1'b0;
      rst_iserdes_q <= 1'b1;
      idelay_rst_q  <= 1'b1;
      idelay_ce_q   <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tap_cur_q     <= tap_cur_d;
      tap_sel_q     <= tap_sel_d;
      win_len_q     <= win_len_d;
      pass_q        <= pass_d;
      run_open_q    <= run_open_d;
      run_start_q   <= run_start_d;
      run_len_q     <= run_len_d;
      best_start_q  <= best_start_d;
      best_len_q    <= best_len_d;
      move_idle_q   <= move_idle_d;
      rst_iserdes_q <= rst_iserdes_d;
      idelay_rst_q  <= idelay_rst_d;
      idelay_ce_q   <= idelay_ce_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign rst_iserdes_sync = rst_iserdes_q;
  assign idelay_rst       = idelay_rst_q;
  assign idelay_ce        = idelay_ce_q;
  assign idelay_inc       = 1'b1;
  assign tap_cur          = tap_cur_q;
  assign tap_sel          = tap_sel_q;
  assign win_len          = win_len_q;
  assign train_done       = done_q;
  assign train_fail       = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_idelay_train.sv
// ----------------------------------------------------------------------------
// tb_adc_idelay_train : directed bench with a tap-dependent ADC model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adc_idelay_train;

  localparam int          TAP_NUM = 32;
  localparam int          TAP_W   = 5;
  localparam int          S       = 16;
  localparam int          C       = 64;
  localparam logic [15:0] PAT     = 16'hA55A;
  localparam int          SWEEP   = 8 + TAP_NUM * (S + C + 2) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              train_start;
  logic [15:0]       adc = PAT;
  logic              rst_iserdes_sync, idelay_rst, idelay_ce, idelay_inc;
  logic [TAP_W-1:0]  tap_cur, tap_sel;
  logic [TAP_W:0]    win_len;
  logic              train_done, train_fail;

  always #5 clk = ~clk;

  adc_idelay_train dut (
    .adc_clk_bufr     (clk),
    .rst_train_sync   (rst),
    .train_start      (train_start),
    .adc_parrel_i     (adc),
    .rst_iserdes_sync (rst_iserdes_sync),
    .idelay_rst       (idelay_rst),
    .idelay_ce        (idelay_ce),
    .idelay_inc       (idelay_inc),
    .tap_cur          (tap_cur),
    .tap_sel          (tap_sel),
    .win_len          (win_len),
    .train_done       (train_done),
    .train_fail       (train_fail)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // IDELAY model plus a capture stage that sees the pattern only on masked taps
  logic [TAP_W-1:0] model_tap = '0;
  int               tap_age   = 0;
  logic [31:0]      mask      = '1;
  bit               glitch_en = 1'b0;

  always @(posedge clk) begin
    if (idelay_rst === 1'b1) begin
      model_tap <= '0;
      tap_age   <= 0;
    end else if (idelay_ce === 1'b1) begin
      model_tap <= model_tap + 1'b1;
      tap_age   <= 0;
    end else begin
      tap_age <= tap_age + 1;
    end
  end

  always @(negedge clk) begin
    if (mask[model_tap] === 1'b1)
      adc = (glitch_en && model_tap == 5'd10 && tap_age == 40) ? (PAT ^ 16'h0001) : PAT;
    else
      adc = ~PAT;
  end

  int viol     = 0;
  int move_cnt = 0;
  bit prev_ce  = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (idelay_ce === 1'b1 && idelay_rst === 1'b1) viol++;
      if (idelay_ce === 1'b1 && prev_ce) viol++;
    end
    prev_ce = (idelay_ce === 1'b1);
    if (idelay_rst === 1'b1) move_cnt = 0;
    else if (idelay_ce === 1'b1) move_cnt++;
  end

  typedef struct {
    string tag;
    bit    fail;
    int    sel;
    int    win;
    int    lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_run(input string tag, input bit f, input int sel, input int win);
    exp_t e;
    e.tag  = tag;
    e.fail = f;
    e.sel  = sel;
    e.win  = win;
    e.lat  = f ? SWEEP + 1 : SWEEP + 2 + 2 * sel + S;
    exp_q.push_back(e);
  endtask

  task automatic await_result(input int t0);
    exp_t e;
    bit   to;
    int   lat;
    to = 1'b0;
    while (!(train_done === 1'b1 || train_fail === 1'b1)) begin
      @(posedge clk); #1;
      if (cyc - t0 > 6000) begin
        to = 1'b1;
        break;
      end
    end
    lat = cyc - t0;
    e = exp_q.pop_front();
    chk({e.tag, "/timeout"}, 32'(to), 32'd0);
    chk({e.tag, "/done"}, 32'(train_done), 32'(!e.fail));
    chk({e.tag, "/fail"}, 32'(train_fail), 32'(e.fail));
    chk({e.tag, "/latency"}, lat, e.lat);
    if (!e.fail) begin
      chk({e.tag, "/tap_sel"}, 32'(tap_sel), e.sel);
      chk({e.tag, "/win_len"}, 32'(win_len), e.win);
      chk({e.tag, "/tap_cur"}, 32'(tap_cur), e.sel);
      chk({e.tag, "/idelay_tap"}, 32'(model_tap), e.sel);
      chk({e.tag, "/move_pulses"}, move_cnt, e.sel);
    end else begin
      chk({e.tag, "/tap_cur"}, 32'(tap_cur), 32'd0);
      chk({e.tag, "/sweep_pulses_only"}, move_cnt, TAP_NUM - 1);
    end
    chk({e.tag, "/ce_protocol"}, viol, 32'd0);
  endtask

  task automatic restart(output int t0);
    train_start = 1'b1;
    @(posedge clk); #1;
    train_start = 1'b0;
    t0 = cyc;
    chk("restart/done_clr", 32'(train_done), 32'd0);
    chk("restart/fail_clr", 32'(train_fail), 32'd0);
    chk("restart/win_len_clr", 32'(win_len), 32'd0);
    chk("restart/rst_iserdes", 32'(rst_iserdes_sync), 32'd1);
  endtask

  initial begin
    int t0;
    int n;
    rst         = 1'b1;
    train_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/rst_iserdes", 32'(rst_iserdes_sync), 32'd1);
    chk("reset/idelay_rst", 32'(idelay_rst), 32'd1);
    chk("reset/idelay_ce", 32'(idelay_ce), 32'd0);
    chk("reset/idelay_inc", 32'(idelay_inc), 32'd1);
    chk("reset/tap_cur", 32'(tap_cur), 32'd0);
    chk("reset/tap_sel", 32'(tap_sel), 32'd0);
    chk("reset/win_len", 32'(win_len), 32'd0);
    chk("reset/train_done", 32'(train_done), 32'd0);
    chk("reset/train_fail", 32'(train_fail), 32'd0);

    expect_run("all_pass", 1'b0, 15, 32);
    rst = 1'b0;
    t0  = cyc;
    @(posedge clk); #1;
    chk("rst_first/idelay_rst_drop", 32'(idelay_rst), 32'd0);
    chk("rst_first/rst_iserdes_held", 32'(rst_iserdes_sync), 32'd1);
    await_result(t0);
    repeat (5) @(posedge clk);
    #1;
    chk("all_pass/hold", 32'(train_done), 32'd1);

    mask = 32'h0003_FFC0;
    expect_run("window_6_17", 1'b0, 11, 12);
    restart(t0);
    chk("restart/tap_sel_kept", 32'(tap_sel), 32'd15);
    await_result(t0);

    mask = 32'h00F0_003C;
    expect_run("tie_2_5_20_23", 1'b0, 3, 4);
    restart(t0);
    await_result(t0);

    mask      = 32'h0000_1F00;
    glitch_en = 1'b1;
    expect_run("glitch_tap10", 1'b0, 8, 2);
    restart(t0);
    await_result(t0);
    glitch_en = 1'b0;

    mask = 32'h0000_0000;
    expect_run("never_match", 1'b1, 0, 0);
    restart(t0);
    await_result(t0);

    mask = '1;
    expect_run("retrain_after_fail", 1'b0, 15, 32);
    restart(t0);
    await_result(t0);

    restart(t0);
    n = 0;
    while (model_tap != 5'd20 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midreset/reach_tap20", 32'(model_tap), 32'd20);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset/rst_iserdes", 32'(rst_iserdes_sync), 32'd1);
    chk("midreset/idelay_rst", 32'(idelay_rst), 32'd1);
    chk("midreset/tap_cur", 32'(tap_cur), 32'd0);
    chk("midreset/tap_sel", 32'(tap_sel), 32'd0);
    rst = 1'b0;
    t0  = cyc;
    expect_run("midreset_resweep", 1'b0, 15, 32);
    repeat (100) @(posedge clk);
    #1;
    train_start = 1'b1;
    @(posedge clk); #1;
    train_start = 1'b0;
    await_result(t0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
